// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and the
// architectural reset/bubble constants.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    MISS  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_INST = 32'h0000_0000;
  localparam int          INST_BYTES  = 4;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues icache requests, absorbs misses,
// stalls and ID-stage redirects, and feeds the IF/ID register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC    = if_fetch_stage_pkg::RESET_PC,
  parameter logic [31:0] BUBBLE_INST = if_fetch_stage_pkg::BUBBLE_INST
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             stall_i,
  input  logic                             branch_i,
  input  logic [31:0]                      branch_target_i,
  output logic                             imem_req_o,
  output logic [31:0]                      imem_addr_o,
  input  logic                             imem_ready_i,
  input  logic [31:0]                      imem_data_i,
  output logic [31:0]                      pc_o,
  output logic [31:0]                      instruction_o,
  output logic                             flush_o,
  output logic                             stall_o,
  output if_fetch_stage_pkg::fetch_state_t state_o
);

  import if_fetch_stage_pkg::*;

  // Handshake: imem_req_o/imem_addr_o stay asserted and stable from the first
  // request cycle until imem_ready_i is seen; imem_data_i is only consumed in
  // that ready cycle, and a request is never withdrawn before completion.

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  inst_buf;
  logic         redir_pend;
  logic [31:0]  redir_pc;
  logic [31:0]  pc_inc;

  assign pc_inc      = pc_q + 32'(INST_BYTES);
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign stall_o     = stall_i;
  assign state_o     = state;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q       <= RESET_PC;
      state      <= FETCH;
      inst_buf   <= '0;
      redir_pend <= 1'b0;
      redir_pc   <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready_i) begin
            if (branch_i) begin
              pc_q <= branch_target_i;
            end else if (stall_i) begin
              state    <= HOLD;
              inst_buf <= imem_data_i;
            end else begin
              pc_q <= pc_inc;
            end
          end else begin
            state <= MISS;
            if (branch_i) begin
              redir_pend <= 1'b1;
              redir_pc   <= branch_target_i;
            end
          end
        end
        MISS: begin
          if (imem_ready_i) begin
            // A redirect seen at any point during the miss discards the word;
            // a same-cycle branch is newer than the remembered one.
            if (branch_i) begin
              pc_q       <= branch_target_i;
              redir_pend <= 1'b0;
              state      <= FETCH;
            end else if (redir_pend) begin
              pc_q       <= redir_pc;
              redir_pend <= 1'b0;
              state      <= FETCH;
            end else if (stall_i) begin
              state    <= HOLD;
              inst_buf <= imem_data_i;
            end else begin
              pc_q  <= pc_inc;
              state <= FETCH;
            end
          end else if (branch_i) begin
            redir_pend <= 1'b1;
            redir_pc   <= branch_target_i;
          end
        end
        HOLD: begin
          if (branch_i) begin
            pc_q  <= branch_target_i;
            state <= FETCH;
          end else if (!stall_i) begin
            pc_q  <= pc_inc;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req_o    = 1'b0;
    instruction_o = BUBBLE_INST;
    flush_o       = 1'b1;
    if (rst_i) begin
      case (state)
        FETCH: begin
          imem_req_o = 1'b1;
          if (imem_ready_i) begin
            instruction_o = imem_data_i;
            flush_o       = branch_i;
          end
        end
        MISS: begin
          imem_req_o = 1'b1;
          if (imem_ready_i && !redir_pend && !branch_i) begin
            instruction_o = imem_data_i;
            flush_o       = 1'b0;
          end
        end
        HOLD: begin
          instruction_o = inst_buf;
          flush_o       = branch_i;
        end
        default: begin
          imem_req_o    = 1'b0;
          instruction_o = BUBBLE_INST;
          flush_o       = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios, then random stall/branch/latency
// traffic checked against a program-order model of delivered instructions.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic         clk_i;
  logic         rst_i;
  logic         stall_i;
  logic         branch_i;
  logic [31:0]  branch_target_i;
  logic         imem_req_o;
  logic [31:0]  imem_addr_o;
  logic         imem_ready_i;
  logic [31:0]  imem_data_i;
  logic [31:0]  pc_o;
  logic [31:0]  instruction_o;
  logic         flush_o;
  logic         stall_o;
  fetch_state_t dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int delivered = 0;
  logic rand_on = 1'b0;
  logic [31:0] exp_q[$];

  if_fetch_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
    .imem_data_i(imem_data_i), .pc_o(pc_o), .instruction_o(instruction_o),
    .flush_o(flush_o), .stall_o(stall_o), .state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic rdy, input logic stl, input logic br, input logic [31:0] tgt);
    imem_ready_i    = rdy;
    imem_data_i     = rdy ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;
    stall_i         = stl;
    branch_i        = br;
    branch_target_i = tgt;
  endtask

  task automatic cycle(input logic rdy, input logic stl, input logic br, input logic [31:0] tgt);
    @(posedge clk_i); #1;
    apply(rdy, stl, br, tgt);
    @(negedge clk_i);
  endtask

  task automatic chk_out(input string nm, input logic req, input logic [31:0] addr,
                         input logic flush, input logic [31:0] inst, input logic chk_inst);
    chk({nm, "_req"},   {31'b0, imem_req_o}, {31'b0, req});
    chk({nm, "_addr"},  imem_addr_o, addr);
    chk({nm, "_pc"},    pc_o, addr);
    chk({nm, "_flush"}, {31'b0, flush_o}, {31'b0, flush});
    if (chk_inst) chk({nm, "_inst"}, instruction_o, inst);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_i) begin
    if (rand_on && rst_i) begin
      chk("stall_pass", {31'b0, stall_o}, {31'b0, stall_i});
      if (branch_i) begin
        chk("branch_flush", {31'b0, flush_o}, 32'd1);
      end else if (!flush_o && !stall_i) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL deliver: unexpected delivery pc 0x%08h with empty queue", pc_o);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("deliver_pc", pc_o, e);
          chk("deliver_inst", instruction_o, mem_word(e));
          exp_q.push_back(e + 32'd4);
          delivered++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        busy;
    logic [31:0] busy_addr;
    int          lat;
    logic        br, stl, rdy;
    logic [31:0] tgt, dat;

    rst_i = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 32'h0);
    #3;
    chk_out("reset", 1'b0, RESET_PC, 1'b1, BUBBLE_INST, 1'b1);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    apply(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    chk_out("hit0", 1'b1, 32'h0, 1'b0, mem_word(32'h0), 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("hit4", 1'b1, 32'h4, 1'b0, mem_word(32'h4), 1'b1);

    // Three-cycle miss at 0x8, data on the fourth.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      chk_out("miss8", 1'b1, 32'h8, 1'b1, BUBBLE_INST, 1'b1);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("miss8_data", 1'b1, 32'h8, 1'b0, mem_word(32'h8), 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("hitC", 1'b1, 32'hC, 1'b0, mem_word(32'hC), 1'b1);

    // Stall on a hit at 0x10: HOLD presents the buffered word without requesting.
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk_out("stall_hit", 1'b1, 32'h10, 1'b0, mem_word(32'h10), 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk_out("hold1", 1'b0, 32'h10, 1'b0, mem_word(32'h10), 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("hold_rel", 1'b0, 32'h10, 1'b0, mem_word(32'h10), 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("hit14", 1'b1, 32'h14, 1'b0, mem_word(32'h14), 1'b1);

    // Branch to 0x100 in the second miss cycle: returned word is discarded.
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("miss18", 1'b1, 32'h18, 1'b1, BUBBLE_INST, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h100);
    chk_out("miss18_br", 1'b1, 32'h18, 1'b1, BUBBLE_INST, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("miss18_drop", 1'b1, 32'h18, 1'b1, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("hit100", 1'b1, 32'h100, 1'b0, mem_word(32'h100), 1'b1);

    // Branch and stall together on a hit: branch wins.
    cycle(1'b1, 1'b1, 1'b1, 32'h40);
    chk_out("br_stall", 1'b1, 32'h104, 1'b1, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("hit40", 1'b1, 32'h40, 1'b0, mem_word(32'h40), 1'b1);

    // Reset asserted in the middle of a miss at 0x20.
    cycle(1'b1, 1'b0, 1'b1, 32'h20);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("miss20", 1'b1, 32'h20, 1'b1, BUBBLE_INST, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    chk_out("mid_reset", 1'b0, RESET_PC, 1'b1, BUBBLE_INST, 1'b1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    apply(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    chk_out("post_reset", 1'b1, RESET_PC, 1'b0, mem_word(RESET_PC), 1'b1);

    // PC wrap from the top of the address space.
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("hit_top", 1'b1, 32'hFFFF_FFFC, 1'b0, mem_word(32'hFFFF_FFFC), 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("wrap", 1'b1, 32'h0, 1'b0, mem_word(32'h0), 1'b1);

    // Random phase: responder with 0..3 cycles of latency, random stalls/branches.
    busy = 1'b0;
    busy_addr = '0;
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_i); #1;
      br  = (i == 0) || ($urandom_range(0, 9) == 0);
      tgt = $urandom();
      tgt[1:0] = 2'b00;
      stl = ($urandom_range(0, 3) == 0);
      rdy = 1'b0;
      dat = $urandom();
      if (imem_req_o) begin
        if (!busy) begin
          busy = 1'b1;
          busy_addr = imem_addr_o;
          lat = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
        end else begin
          chk("addr_held", imem_addr_o, busy_addr);
        end
        if (lat == 0) begin
          rdy = 1'b1;
          dat = mem_word(busy_addr);
          busy = 1'b0;
        end else begin
          lat--;
        end
      end else begin
        chk("no_abandon", {31'b0, busy}, 32'd0);
      end
      imem_ready_i    = rdy;
      imem_data_i     = dat;
      stall_i         = stl;
      branch_i        = br;
      branch_target_i = tgt;
      if (br) begin
        exp_q.delete();
        exp_q.push_back(tgt);
      end
      rand_on = 1'b1;
    end
    @(negedge clk_i);
    rand_on = 1'b0;
    chk("progress", {31'b0, (delivered >= 100) ? 1'b1 : 1'b0}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
